// File: rtl/edge_map_builder_pkg.sv
`default_nettype none
//==== edge_map_builder_pkg : frame geometry, edge code and FSM states | rev 1.0 ====

package edge_map_builder_pkg;

   localparam int WIDTH      = 640;
   localparam int HEIGHT     = 480;
   localparam int IMG_PIXELS = WIDTH * HEIGHT;
   localparam int ADDR_W     = $clog2(IMG_PIXELS);
   localparam int BIN_W      = 3;
   localparam int COL_W      = $clog2(WIDTH);
   localparam int ROW_W      = $clog2(HEIGHT);
   localparam int CNT_W      = 12;

   localparam logic [BIN_W-1:0] EDGE_VAL = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/edge_map_builder_window.sv
`default_nettype none
//==== mask_window_3row : two-row-plus-one mask window with centre row/col tracking | rev 1.0 ====

module mask_window_3row #(
   parameter int WIDTH  = edge_map_builder_pkg::WIDTH,
   parameter int HEIGHT = edge_map_builder_pkg::HEIGHT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic shift_i,
   input  logic bit_i,
   output logic centre_o,
   output logic up_o,
   output logic down_o,
   output logic left_o,
   output logic right_o,
   output logic centre_valid_o
);
   import edge_map_builder_pkg::*;

   localparam int                 WIN_BITS = 2 * WIDTH + 1;
   localparam logic [COL_W-1:0]   LAST_COL = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(HEIGHT - 1);
   localparam logic [COL_W:0]     PRIME    = (COL_W + 1)'(WIDTH);

   logic [WIN_BITS-1:0] win_q, win_d;
   logic [COL_W:0]      fill_q, fill_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic                run_q, run_d;
   logic                fin_q, fin_d;
   logic                cv_q, cv_d;
   logic                last_px;

   assign last_px = (col_q == LAST_COL) && (row_q == LAST_ROW);

   // The first centre appears on the shift after WIDTH bits are already queued.
   always_comb begin
      win_d  = win_q;
      fill_d = fill_q;
      col_d  = col_q;
      row_d  = row_q;
      run_d  = run_q;
      fin_d  = fin_q;
      cv_d   = 1'b0;
      if (clear_i) begin
         win_d  = '0;
         fill_d = '0;
         col_d  = '0;
         row_d  = '0;
         run_d  = 1'b0;
         fin_d  = 1'b0;
      end else if (shift_i) begin
         win_d = {win_q[WIN_BITS-2:0], bit_i};
         if (fill_q != PRIME) begin
            fill_d = fill_q + 1'b1;
         end else if (!run_q && !fin_q) begin
            run_d = 1'b1;
            cv_d  = 1'b1;
            col_d = '0;
            row_d = '0;
         end else if (run_q) begin
            if (last_px) begin
               run_d = 1'b0;
               fin_d = 1'b1;
            end else begin
               cv_d = 1'b1;
               if (col_q == LAST_COL) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_q  <= '0;
         fill_q <= '0;
         col_q  <= '0;
         row_q  <= '0;
         run_q  <= 1'b0;
         fin_q  <= 1'b0;
         cv_q   <= 1'b0;
      end else begin
         win_q  <= win_d;
         fill_q <= fill_d;
         col_q  <= col_d;
         row_q  <= row_d;
         run_q  <= run_d;
         fin_q  <= fin_d;
         cv_q   <= cv_d;
      end
   end

   // Border masking by counters keeps the previous/next row from leaking across the wrap.
   assign centre_o       = win_q[WIDTH];
   assign up_o           = (row_q != '0)       && win_q[2*WIDTH];
   assign down_o         = (row_q != LAST_ROW) && win_q[0];
   assign left_o         = (col_q != '0)       && win_q[WIDTH+1];
   assign right_o        = (col_q != LAST_COL) && win_q[WIDTH-1];
   assign centre_valid_o = cv_q;

endmodule

`default_nettype wire

// File: rtl/edge_map_builder.sv
`default_nettype none
//==== edge_map_builder : raster-scans a 1-bit mask and writes a boundary-pixel map | rev 1.0 ====

module edge_map_builder #(
   parameter int WIDTH    = edge_map_builder_pkg::WIDTH,
   parameter int HEIGHT   = edge_map_builder_pkg::HEIGHT,
   parameter int READ_LAT = 2,
   parameter logic [edge_map_builder_pkg::BIN_W-1:0] EDGE_VAL = edge_map_builder_pkg::EDGE_VAL
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       start,
   output logic [edge_map_builder_pkg::ADDR_W-1:0]    mask_addr_read,
   input  logic                                       mask_read,
   output logic [edge_map_builder_pkg::ADDR_W-1:0]    edge_addr_write,
   output logic [edge_map_builder_pkg::BIN_W-1:0]     edge_write,
   output logic                                       edge_we,
   output logic [edge_map_builder_pkg::CNT_W-1:0]     num_pixels,
   output logic                                       done
);
   import edge_map_builder_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
   localparam logic [COL_W:0]    FLUSH_LEN = (COL_W + 1)'(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_e              state_q, state_d;
   logic                start_q;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                rd_vld_q, rd_vld_d;
   logic                rd_zero_q, rd_zero_d;
   logic [COL_W:0]      flush_cnt_q, flush_cnt_d;
   logic [READ_LAT-1:0] vld_pipe_q, zero_pipe_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [CNT_W-1:0]    num_q;
   logic                clear_win;
   logic                win_shift, win_bit;
   logic                c_px, up_px, dn_px, lf_px, rt_px, c_vld;
   logic                is_edge;

   always_ff @(posedge clk) begin
      start_q <= start;
   end

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      rd_vld_d    = 1'b0;
      rd_zero_d   = 1'b0;
      flush_cnt_d = flush_cnt_q;
      clear_win   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && !start_q) begin
               state_d   = S_SCAN;
               rd_addr_d = '0;
               rd_vld_d  = 1'b1;
               clear_win = 1'b1;
            end
         end
         S_SCAN: begin
            rd_vld_d = 1'b1;
            if (rd_addr_q == LAST_ADDR) begin
               state_d     = S_FLUSH;
               rd_zero_d   = 1'b1;
               flush_cnt_d = (COL_W + 1)'(1);
            end else begin
               rd_addr_d = rd_addr_q + 1'b1;
            end
         end
         S_FLUSH: begin
            // Zero slots ride the tag pipe so they queue behind the last real reads.
            if (flush_cnt_q != FLUSH_LEN) begin
               rd_vld_d    = 1'b1;
               rd_zero_d   = 1'b1;
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
            if (c_vld && (wr_addr_q == LAST_ADDR)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rd_addr_q   <= '0;
         rd_vld_q    <= 1'b0;
         rd_zero_q   <= 1'b0;
         flush_cnt_q <= '0;
         vld_pipe_q  <= '0;
         zero_pipe_q <= '0;
      end else begin
         state_q       <= state_d;
         rd_addr_q     <= rd_addr_d;
         rd_vld_q      <= rd_vld_d;
         rd_zero_q     <= rd_zero_d;
         flush_cnt_q   <= flush_cnt_d;
         vld_pipe_q[0]  <= rd_vld_q;
         zero_pipe_q[0] <= rd_zero_q;
         for (int i = 1; i < READ_LAT; i++) begin
            vld_pipe_q[i]  <= vld_pipe_q[i-1];
            zero_pipe_q[i] <= zero_pipe_q[i-1];
         end
      end
   end

   assign win_shift = vld_pipe_q[READ_LAT-1];
   assign win_bit   = mask_read && !zero_pipe_q[READ_LAT-1];

   mask_window_3row #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_window (
      .clk            (clk),
      .rst            (rst),
      .clear_i        (clear_win),
      .shift_i        (win_shift),
      .bit_i          (win_bit),
      .centre_o       (c_px),
      .up_o           (up_px),
      .down_o         (dn_px),
      .left_o         (lf_px),
      .right_o        (rt_px),
      .centre_valid_o (c_vld)
   );

   assign is_edge = c_px && !(up_px && dn_px && lf_px && rt_px);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr_q <= '0;
         num_q     <= '0;
      end else if (clear_win) begin
         wr_addr_q <= '0;
         num_q     <= '0;
      end else if (c_vld) begin
         wr_addr_q <= wr_addr_q + 1'b1;
         if (is_edge && (num_q != CNT_MAX)) begin
            num_q <= num_q + 1'b1;
         end
      end
   end

   assign mask_addr_read  = rd_addr_q;
   assign edge_addr_write = wr_addr_q;
   assign edge_we         = c_vld;
   assign edge_write      = (c_vld && is_edge) ? EDGE_VAL : '0;
   assign num_pixels      = num_q;
   assign done            = (state_q == S_DONE);

endmodule

`default_nettype wire
